axis_snapshot_sched: RTL and testbench

- Sequencer for the stream snapshot datapath. It watches an AXI4-Stream beat flow and holds one captured word in a register.
- Software starts a capture with a pulse. Capture is either single-shot or periodic, every cfg_period cycles.
- The block exposes the held word, a done/overrun handshake and a capture counter to the register bank.
- It sits between the ADC/filter stream and the AXI-lite status registers and never stalls the stream.

---
 rtl/axis_snapshot_sched.sv | 158 +++++++++++++++
 tb/tb_axis_snapshot_sched.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_snapshot_sched.sv
// axis_snapshot_sched: snapshot sequencer for an AXI4-Stream beat flow.
// Holds one captured word. Capture is started by software, either single-shot
// or periodic (one arm event every max(cfg_period,1) cycles).
// The stream is never stalled: s_axis_tready is a pass-through of m_axis_tready.
// Optional feature macro: SNAPSHOT_TIMESTAMP_EN adds a free-running counter
// and a ts output latched together with data on every capture.
//
// Handshake: a beat is s_axis_tvalid & m_axis_tready in the same cycle; this
// block only observes beats and never holds ready low on its own.
module axis_snapshot_sched #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int CNTR_WIDTH       = 32,
  parameter int CAPT_CNT_WIDTH   = 16
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [CNTR_WIDTH-1:0]       cfg_period,
  input  logic                        cfg_periodic,
  input  logic                        start,
  input  logic                        stop,
  input  logic                        ack,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  input  logic                        m_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] data,
  output logic                        done,
  output logic                        overrun,
  output logic                        busy,
`ifdef SNAPSHOT_TIMESTAMP_EN
  output logic [CNTR_WIDTH-1:0]       ts,
`endif
  output logic [CAPT_CNT_WIDTH-1:0]   capt_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ARMED = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [CNTR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    mode_q, mode_d;
  logic                    beat;
  logic                    capture;
  logic [CNTR_WIDTH-1:0]   reload;

  assign beat          = s_axis_tvalid & m_axis_tready;
  assign s_axis_tready = m_axis_tready;
  assign busy          = (state_q != ST_IDLE);

  // A period of 0 behaves like 1.
  assign reload = (cfg_period == '0) ? '0 : cfg_period - CNTR_WIDTH'(1);

  // State register and period down-counter.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  // Next-state logic. The counter reaching 0 coincides with entering ARMED,
  // so the spacing between arm events is exactly max(cfg_period,1) cycles;
  // a reload value of 0 re-arms immediately (capture every cycle).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d = cfg_periodic;
          if (cfg_periodic) begin
            state_d = ST_WAIT;
            cnt_d   = reload;
          end else begin
            state_d = ST_ARMED;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0 || cnt_q == CNTR_WIDTH'(1)) begin
          state_d = ST_ARMED;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q - CNTR_WIDTH'(1);
        end
      end
      ST_ARMED: begin
        if (beat) begin
          capture = 1'b1;
          if (mode_q) begin
            cnt_d   = reload;
            state_d = (reload == '0) ? ST_ARMED : ST_WAIT;
          end else begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // stop overrides everything, including a coincident capture.
    if (stop) begin
      state_d = ST_IDLE;
      capture = 1'b0;
    end
  end

  // Captured word, capture counter and the sticky done/overrun flags.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      data       <= '0;
      capt_count <= '0;
      done       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (capture) begin
        data       <= s_axis_tdata;
        capt_count <= capt_count + CAPT_CNT_WIDTH'(1);
        done       <= 1'b1;
        // With ack in the same cycle the old overrun is discarded and only
        // the pre-edge done decides.
        overrun    <= ack ? done : (overrun | done);
      end else if (ack) begin
        done       <= 1'b0;
        overrun    <= 1'b0;
      end
    end
  end

`ifdef SNAPSHOT_TIMESTAMP_EN
  logic [CNTR_WIDTH-1:0] free_cnt;

  // Free-running timestamp counter and its capture register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      free_cnt <= '0;
      ts       <= '0;
    end else begin
      free_cnt <= free_cnt + CNTR_WIDTH'(1);
      if (capture) ts <= free_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_axis_snapshot_sched.sv
// tb_axis_snapshot_sched: directed bench for axis_snapshot_sched.
module tb_axis_snapshot_sched;

  localparam int DW = 32;
  localparam int CW = 32;
  localparam int KW = 16;

  logic          aclk;
  logic          aresetn;
  logic [CW-1:0] cfg_period;
  logic          cfg_periodic;
  logic          start;
  logic          stop;
  logic          ack;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          m_axis_tready;
  logic [DW-1:0] data;
  logic          done;
  logic          overrun;
  logic          busy;
  logic [KW-1:0] capt_count;
`ifdef SNAPSHOT_TIMESTAMP_EN
  logic [CW-1:0] ts;
`endif

  int n_checks;
  int n_errors;
  logic [KW-1:0] exp_count;

  axis_snapshot_sched #(
    .AXIS_TDATA_WIDTH(DW),
    .CNTR_WIDTH(CW),
    .CAPT_CNT_WIDTH(KW)
  ) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .cfg_period(cfg_period),
    .cfg_periodic(cfg_periodic),
    .start(start),
    .stop(stop),
    .ack(ack),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axis_tready(m_axis_tready),
    .data(data),
    .done(done),
    .overrun(overrun),
    .busy(busy),
`ifdef SNAPSHOT_TIMESTAMP_EN
    .ts(ts),
`endif
    .capt_count(capt_count)
  );

  // Clock.
  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs set afterwards are seen at the following edge.
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic pulse_start(input logic periodic);
    cfg_periodic = periodic;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    exp_count = '0;
    aresetn = 1'b0;
    cfg_period = '0;
    cfg_periodic = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    ack = 1'b0;
    s_axis_tdata = '0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;

    // Reset state.
    #13;
    check("rst_data", data, 0);
    check("rst_done", done, 0);
    check("rst_overrun", overrun, 0);
    check("rst_busy", busy, 0);
    check("rst_count", capt_count, 0);
    tick();
    aresetn = 1'b1;
    tick();

    // Single-shot: start at t0, beat at t0+3.
    pulse_start(1'b0);
    check("ss_busy", busy, 1);
    tick();
    tick();
    check("ss_done_pre", done, 0);
    s_axis_tvalid = 1'b1;
    m_axis_tready = 1'b1;
    s_axis_tdata = 32'hA5A5_0001;
    tick();
    s_axis_tvalid = 1'b0;
    exp_count = exp_count + 1;
    check("ss_data", data, 32'hA5A5_0001);
    check("ss_done", done, 1);
    check("ss_count", capt_count, exp_count);
    tick();
    tick();
    check("ss_hold_busy", busy, 1);
    check("ss_hold_count", capt_count, exp_count);
    pulse_ack();
    check("ss_ack_busy", busy, 0);
    check("ss_ack_done", done, 0);

    // Periodic, period 4, tdata = edge index; captures at edges 4, 8, 12.
    cfg_period = 4;
    s_axis_tvalid = 1'b1;
    s_axis_tdata = 0;
    pulse_start(1'b1);
    for (int i = 1; i <= 12; i++) begin
      s_axis_tdata = i;
      tick();
      if (i == 3) check("per_nocap3", capt_count, exp_count);
      if (i == 4) begin
        exp_count = exp_count + 1;
        check("per_data4", data, 4);
        check("per_done4", done, 1);
        check("per_ovr4", overrun, 0);
        check("per_count4", capt_count, exp_count);
      end
      if (i == 7) check("per_data7", data, 4);
      if (i == 8) begin
        exp_count = exp_count + 1;
        check("per_data8", data, 8);
        check("per_ovr8", overrun, 1);
      end
      if (i == 12) begin
        exp_count = exp_count + 1;
        check("per_data12", data, 12);
        check("per_count12", capt_count, exp_count);
      end
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    s_axis_tvalid = 1'b0;
    check("per_stop_busy", busy, 0);
    pulse_ack();
    check("per_ack_ovr", overrun, 0);

    // Back-pressure: valid without ready for 10 cycles.
    pulse_start(1'b0);
    s_axis_tvalid = 1'b1;
    s_axis_tdata = 32'h0000_1234;
    m_axis_tready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_tready", s_axis_tready, 0);
      check("bp_count", capt_count, exp_count);
    end
    m_axis_tready = 1'b1;
    #1;
    check("bp_tready_hi", s_axis_tready, 1);
    tick();
    s_axis_tvalid = 1'b0;
    exp_count = exp_count + 1;
    check("bp_data", data, 32'h0000_1234);
    check("bp_count_cap", capt_count, exp_count);
    pulse_ack();

    // stop coincident with a beat in ARMED.
    pulse_start(1'b0);
    s_axis_tvalid = 1'b1;
    s_axis_tdata = 32'hDEAD_0000;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    s_axis_tvalid = 1'b0;
    check("stop_busy", busy, 0);
    check("stop_data", data, 32'h0000_1234);
    check("stop_count", capt_count, exp_count);
    check("stop_done", done, 0);

    // ack coincident with a capture while done=0.
    pulse_start(1'b0);
    s_axis_tvalid = 1'b1;
    s_axis_tdata = 32'hBEEF_0000;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    s_axis_tvalid = 1'b0;
    exp_count = exp_count + 1;
    check("ackcap_done", done, 1);
    check("ackcap_ovr", overrun, 0);
    check("ackcap_data", data, 32'hBEEF_0000);
    pulse_ack();

    // Period 0: WAIT one cycle, then a capture every cycle; count wraps.
    cfg_period = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata = 32'h0000_0077;
    pulse_start(1'b1);
    tick();
    check("p0_count1", capt_count, exp_count);
    tick();
    check("p0_count2", capt_count, exp_count + 16'd1);
    tick();
    check("p0_count3", capt_count, exp_count + 16'd2);
    check("p0_ovr", overrun, 1);
    for (int i = 0; i < 65534; i++) tick();
    check("p0_wrap", capt_count, exp_count);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    s_axis_tvalid = 1'b0;
    pulse_ack();

    // Asynchronous reset in the middle of WAIT.
    cfg_period = 100;
    s_axis_tdata = 32'h5555_5555;
    s_axis_tvalid = 1'b1;
    pulse_start(1'b1);
    tick();
    tick();
    check("wait_busy", busy, 1);
    #2;
    aresetn = 1'b0;
    #1;
    check("ar_busy", busy, 0);
    check("ar_count", capt_count, 0);
    check("ar_data", data, 0);
    check("ar_done", done, 0);
    s_axis_tvalid = 1'b0;
    exp_count = '0;
    tick();
    aresetn = 1'b1;

    // Capture on the 8th edge after reset release.
    pulse_start(1'b0);
    for (int i = 0; i < 6; i++) tick();
    s_axis_tvalid = 1'b1;
    s_axis_tdata = 32'h0000_00C7;
    tick();
    s_axis_tvalid = 1'b0;
    check("post_rst_data", data, 32'h0000_00C7);
    check("post_rst_count", capt_count, 1);
`ifdef SNAPSHOT_TIMESTAMP_EN
    check("ts_value", ts, 7);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
